fifo_uart_tx: RTL and testbench

Serial transmitter that drains bytes from an upstream FIFO's read port and sends each as an asynchronous UART frame (start bit, DATA_WIDTH data bits LSB first, STOP_BITS stop bits) on a single line. It is the consumer on the FIFO's rd_en/rd_data/rd_val port. It issues one-cycle read requests, latches returned data, and paces requests so that only one byte is in flight at a time.

---
 rtl/fifo_uart_tx.sv | 154 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls one byte at a time from a FIFO read port and
// sends it as start bit, DATA_WIDTH data bits (LSB first) and STOP_BITS stop bits.
module fifo_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1,
   parameter int RETRY_GAP    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_rd_val,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
   localparam int GAP_W  = (RETRY_GAP > 1) ? $clog2(RETRY_GAP + 1) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RETRY_GAP - 1);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      START,
      DATA,
      STOP,
      GAP
   } state_t;

   state_t                  state_reg,    state_next;
   logic [BAUD_W-1:0]       baud_cnt_reg, baud_cnt_next;
   logic [BIT_W-1:0]        bit_cnt_reg,  bit_cnt_next;
   logic [GAP_W-1:0]        gap_cnt_reg,  gap_cnt_next;
   logic [DATA_WIDTH-1:0]   shift_reg,    shift_next;
   logic                    baud_last;

   assign baud_last = (baud_cnt_reg == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         gap_cnt_reg  <= '0;
         shift_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         baud_cnt_reg <= baud_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         gap_cnt_reg  <= gap_cnt_next;
         shift_reg    <= shift_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      baud_cnt_next = '0;
      bit_cnt_next  = bit_cnt_reg;
      gap_cnt_next  = '0;
      shift_next    = shift_reg;
      fifo_rd_en    = 1'b0;
      tx            = 1'b1;
      busy          = 1'b0;
      frame_done    = 1'b0;

      case (state_reg)
         IDLE: begin
            bit_cnt_next = '0;
            if (enable) begin
               state_next = REQ;
            end
         end

         REQ: begin
            fifo_rd_en = 1'b1;
            state_next = WAIT;
         end

         // The FIFO response is only meaningful in the cycle after the request.
         WAIT: begin
            if (fifo_rd_val) begin
               shift_next = fifo_rd_data;
               state_next = START;
            end else begin
               state_next = GAP;
            end
         end

         GAP: begin
            if (gap_cnt_reg == GAP_LAST) begin
               state_next = IDLE;
            end else begin
               gap_cnt_next = gap_cnt_reg + GAP_W'(1);
            end
         end

         START: begin
            tx   = 1'b0;
            busy = 1'b1;
            if (baud_last) begin
               state_next = DATA;
            end else begin
               baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
            end
         end

         DATA: begin
            tx   = shift_reg[0];
            busy = 1'b1;
            if (baud_last) begin
               shift_next = shift_reg >> 1;
               if (bit_cnt_reg == DATA_LAST) begin
                  bit_cnt_next = '0;
                  state_next   = STOP;
               end else begin
                  bit_cnt_next = bit_cnt_reg + BIT_W'(1);
               end
            end else begin
               baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
            end
         end

         // Bit counter is reused to count stop bits.
         STOP: begin
            busy = 1'b1;
            if (baud_last) begin
               if (bit_cnt_reg == STOP_LAST) begin
                  frame_done   = 1'b1;
                  bit_cnt_next = '0;
                  state_next   = IDLE;
               end else begin
                  bit_cnt_next = bit_cnt_reg + BIT_W'(1);
               end
            end else begin
               baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a default instance and a 2-stop-bit,
// 4-clocks-per-bit instance, each with its own FIFO model and frame monitor.
module tb_fifo_uart_tx;

   typedef struct {
      logic [7:0] data;
      int         gap;
      logic       abort;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable0, enable1;
   logic       fifo_rd_en0, fifo_rd_en1;
   logic [7:0] rd_data0, rd_data1;
   logic       rd_val0, rd_val1;
   logic       tx0, tx1, busy0, busy1, frame_done0, frame_done1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_req [2];
   int req_count [2];
   int req_q0 [$];
   int watch_mode = 0;
   int idle_viol = 0;

   logic [7:0] fifo_q0 [$];
   logic [7:0] fifo_q1 [$];
   exp_t       exp_q0 [$];
   exp_t       exp_q1 [$];

   fifo_uart_tx dut0 (
      .clk(clk), .reset(reset), .enable(enable0),
      .fifo_rd_en(fifo_rd_en0), .fifo_rd_data(rd_data0), .fifo_rd_val(rd_val0),
      .tx(tx0), .busy(busy0), .frame_done(frame_done0)
   );

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2), .RETRY_GAP(4)) dut1 (
      .clk(clk), .reset(reset), .enable(enable1),
      .fifo_rd_en(fifo_rd_en1), .fifo_rd_data(rd_data1), .fifo_rd_val(rd_val1),
      .tx(tx1), .busy(busy1), .frame_done(frame_done1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic push0(input logic [7:0] d, input int gap, input logic ab);
      exp_t e;
      e.data = d; e.gap = gap; e.abort = ab;
      fifo_q0.push_back(d);
      exp_q0.push_back(e);
   endtask

   task automatic push1(input logic [7:0] d);
      exp_t e;
      e.data = d; e.gap = -1; e.abort = 1'b0;
      fifo_q1.push_back(d);
      exp_q1.push_back(e);
   endtask

   // kind 0 waits for frame_done, kind 1 waits for busy; returns on that negedge.
   task automatic wait_sig(input int which, input int kind, input int limit, input string name);
      bit hit = 0;
      for (int n = 0; n < limit && !hit; n++) begin
         @(negedge clk);
         if (which == 0) hit = (kind == 0) ? (frame_done0 === 1'b1) : (busy0 === 1'b1);
         else            hit = (kind == 0) ? (frame_done1 === 1'b1) : (busy1 === 1'b1);
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL %s: timeout after %0d cycles, got no event, expected event", name, limit);
      end
   endtask

   // FIFO read port: answers a request one cycle later; drives noise otherwise.
   task automatic fifo_model(input int which);
      logic req;
      forever begin
         @(negedge clk);
         req = (which == 0) ? fifo_rd_en0 : fifo_rd_en1;
         @(posedge clk);
         #1;
         if (which == 0) begin
            if (req === 1'b1 && fifo_q0.size() > 0) begin
               rd_val0 = 1'b1; rd_data0 = fifo_q0.pop_front();
            end else begin
               rd_val0 = (req === 1'b1) ? 1'b0 : 1'($urandom_range(0, 1));
               rd_data0 = 8'($urandom);
            end
         end else begin
            if (req === 1'b1 && fifo_q1.size() > 0) begin
               rd_val1 = 1'b1; rd_data1 = fifo_q1.pop_front();
            end else begin
               rd_val1 = (req === 1'b1) ? 1'b0 : 1'($urandom_range(0, 1));
               rd_data1 = 8'($urandom);
            end
         end
      end
   endtask

   task automatic monitor(input int which);
      int cpb, sb, flen, start, done_at, bad, last_done, bi;
      logic [7:0] rx;
      logic t, b, fd, ebit, aborted, empty;
      exp_t e;
      cpb = (which == 0) ? 16 : 4;
      sb  = (which == 0) ? 1 : 2;
      flen = (9 + sb) * cpb;
      last_done = -1000;
      forever begin
         @(negedge clk);
         t = (which == 0) ? tx0 : tx1;
         if (reset !== 1'b0 || t !== 1'b0) continue;
         start = cyc;
         empty = (which == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
         if (empty) begin
            checks++; errors++;
            $display("FAIL unexpected_frame dut%0d: got frame start at cycle %0d, expected none", which, start);
            repeat (flen) @(negedge clk);
            continue;
         end
         e = (which == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
         check($sformatf("latency_dut%0d", which), start - last_req[which], 2);
         if (e.gap >= 0) check($sformatf("gap_dut%0d", which), start - last_done - 1, e.gap);
         bad = 0; done_at = -1; aborted = 1'b0; rx = '0;
         for (int i = 0; i < flen; i++) begin
            if (i > 0) @(negedge clk);
            if (reset === 1'b1) begin
               aborted = 1'b1;
               break;
            end
            t  = (which == 0) ? tx0 : tx1;
            b  = (which == 0) ? busy0 : busy1;
            fd = (which == 0) ? frame_done0 : frame_done1;
            bi = i / cpb;
            ebit = (bi == 0) ? 1'b0 : (bi <= 8) ? e.data[bi-1] : 1'b1;
            if (t !== ebit) bad++;
            if (b !== 1'b1) bad++;
            if (fd === 1'b1 && done_at < 0) done_at = i;
            if (bi >= 1 && bi <= 8 && (i % cpb) == cpb / 2) rx[bi-1] = t;
         end
         check($sformatf("abort_dut%0d", which), int'(aborted), int'(e.abort));
         if (aborted) begin
            $display("dut%0d frame start_cycle=%0d aborted by reset", which, start);
            while (reset === 1'b1) @(negedge clk);
         end else begin
            check($sformatf("frame_data_dut%0d", which), rx, e.data);
            check($sformatf("frame_pattern_errs_dut%0d", which), bad, 0);
            check($sformatf("frame_done_pos_dut%0d", which), done_at, flen - 1);
            last_done = cyc;
            $display("dut%0d frame start_cycle=%0d byte=0x%02h expected=0x%02h", which, start, rx, e.data);
         end
      end
   endtask

   initial fifo_model(0);
   initial fifo_model(1);
   initial monitor(0);
   initial monitor(1);

   initial begin
      last_req[0] = -1000; last_req[1] = -1000;
      req_count[0] = 0; req_count[1] = 0;
      forever begin
         @(negedge clk);
         if (reset === 1'b0) begin
            if (fifo_rd_en0 === 1'b1) begin
               last_req[0] = cyc; req_count[0]++; req_q0.push_back(cyc);
            end
            if (fifo_rd_en1 === 1'b1) begin
               last_req[1] = cyc; req_count[1]++;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
         if (watch_mode != 0 && (tx0 !== 1'b1 || busy0 !== 1'b0)) idle_viol++;
         if (watch_mode == 1 && (fifo_rd_en0 !== 1'b0 || frame_done0 !== 1'b0)) idle_viol++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by %0t, expected completion", $time);
      $fatal(1);
   end

   initial begin
      int base, start_c, bad_diff;
      reset = 1'b1; enable0 = 1'b0; enable1 = 1'b0;
      rd_val0 = 1'b0; rd_val1 = 1'b0; rd_data0 = '0; rd_data1 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_tx", tx0, 1);
      check("reset_rd_en", fifo_rd_en0, 0);
      check("reset_busy", busy0, 0);
      check("reset_frame_done", frame_done0, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Enable low: line stays idle.
      watch_mode = 1; idle_viol = 0;
      repeat (50) @(negedge clk);
      watch_mode = 0;
      check("idle_enable_low", idle_viol, 0);

      // Single byte 0xA5.
      base = req_count[0];
      push0(8'hA5, -1, 1'b0);
      enable0 = 1'b1;
      wait_sig(0, 0, 300, "wait_done_a5");
      enable0 = 1'b0;
      repeat (5) @(negedge clk);
      check("req_count_a5", req_count[0] - base, 1);

      // Back-to-back 0x00, 0xFF: 3 idle cycles between frames.
      base = req_count[0];
      push0(8'h00, -1, 1'b0);
      push0(8'hFF, 3, 1'b0);
      enable0 = 1'b1;
      wait_sig(0, 0, 300, "wait_done_00");
      wait_sig(0, 0, 300, "wait_done_ff");
      enable0 = 1'b0;
      repeat (5) @(negedge clk);
      check("req_count_b2b", req_count[0] - base, 2);

      // Empty FIFO: periodic retries, then a late byte 0x3C.
      req_q0.delete();
      watch_mode = 2; idle_viol = 0;
      enable0 = 1'b1;
      repeat (60) @(negedge clk);
      watch_mode = 0;
      check("retry_idle_line", idle_viol, 0);
      check("retry_count_ge8", int'(req_q0.size() >= 8), 1);
      bad_diff = 7;
      for (int i = 1; i < req_q0.size(); i++)
         if (req_q0[i] - req_q0[i-1] != 7) bad_diff = req_q0[i] - req_q0[i-1];
      check("retry_period", bad_diff, 7);
      push0(8'h3C, -1, 1'b0);
      wait_sig(0, 0, 300, "wait_done_3c");
      enable0 = 1'b0;
      repeat (5) @(negedge clk);

      // Reset during 4th data bit of 0x0F; next frame carries 0x5A.
      push0(8'h0F, -1, 1'b1);
      push0(8'h5A, -1, 1'b0);
      enable0 = 1'b1;
      wait_sig(0, 1, 20, "wait_busy_0f");
      repeat (69) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("after_reset_tx", tx0, 1);
      check("after_reset_busy", busy0, 0);
      wait_sig(0, 0, 300, "wait_done_5a");
      enable0 = 1'b0;
      repeat (5) @(negedge clk);

      // Two stop bits, 4 clocks per bit, enable dropped mid-frame.
      base = req_count[1];
      push1(8'h81);
      enable1 = 1'b1;
      wait_sig(1, 1, 20, "wait_busy_81");
      start_c = cyc;
      repeat (10) @(negedge clk);
      enable1 = 1'b0;
      wait_sig(1, 0, 60, "wait_done_81");
      check("frame_len_81", cyc - start_c + 1, 44);
      repeat (30) @(negedge clk);
      check("req_count_81", req_count[1] - base, 1);
      check("busy_after_81", busy1, 0);
      check("tx_after_81", tx1, 1);

      check("scoreboard_empty", exp_q0.size() + exp_q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
